// File: rtl/peripheral_wb_burst_ram_if.sv
// peripheral_wb_burst_ram_if: Wishbone B3 bus bundle (master drives requests, slave drives responses).
interface peripheral_wb_burst_ram_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic [AW-1:0]   adr;
   logic [DW-1:0]   dat_w;
   logic [DW-1:0]   dat_r;
   logic [DW/8-1:0] sel;
   logic            we;
   logic            cyc;
   logic            stb;
   logic [2:0]      cti;
   logic [1:0]      bte;
   logic            ack;
   logic            err;
   logic            rty;
   modport master(output adr, dat_w, sel, we, cyc, stb, cti, bte, input dat_r, ack, err, rty);
   modport slave(input adr, dat_w, sel, we, cyc, stb, cti, bte, output dat_r, ack, err, rty);
endinterface

// File: rtl/peripheral_wb_burst_ram.sv
// peripheral_wb_burst_ram: Wishbone B3 RAM slave with registered-feedback CTI/BTE bursts and wait states.
// Define PERIPHERAL_WB_ADDR_CHECK_EN to flag and resynchronise burst beats whose address breaks the prediction.
module peripheral_wb_burst_ram #(
   parameter int            AW          = 32,
   parameter int            DW          = 32,
   parameter int            DEPTH       = 256,
   parameter logic [AW-1:0] BASE_ADDR   = '0,
   parameter int            WAIT_STATES = 0
) (
   input logic wb_clk_i,
   input logic wb_rst_i,
   peripheral_wb_burst_ram_if.slave wb
);
   localparam int STEP = DW / 8;
   localparam int LB = $clog2(STEP);
   localparam int IW = $clog2(DEPTH);
   localparam logic [AW:0] TOP = {1'b0, BASE_ADDR} + (AW+1)'(DEPTH * STEP);
   typedef enum logic [1:0] {IDLE, WAIT, ACK, BURST} state_t;
   state_t state, state_n;
   logic [3:0] cnt, cnt_n;
   logic [AW-1:0] beat, pres, base, nxt, wrap_m;
   logic [2:0] cti_q;
   logic [1:0] bte_q;
   logic ack_q, err_q, req, present, lat, mismatch, ack_o, err_o, wr_en, in_r;
   logic [DW-1:0] dat_q, rd, wr_word;
   logic [DW-1:0] mem [DEPTH];
   logic [IW-1:0] wr_idx, rd_idx;
   assign req = wb.cyc & wb.stb;
`ifdef PERIPHERAL_WB_ADDR_CHECK_EN
   assign mismatch = (state == BURST) && (wb.adr != beat);
`else
   assign mismatch = 1'b0;
`endif
   assign ack_o = req & ack_q & !mismatch;
   assign err_o = req & (err_q | (ack_q & mismatch));
   assign wb.ack = ack_o;
   assign wb.err = err_o;
   assign wb.rty = 1'b0;
   assign wb.dat_r = ack_o ? dat_q : '0;
   // beat holds the address of the beat currently being answered; pres is the one answered next
   assign base = mismatch ? wb.adr : beat;
   assign wrap_m = bte_q == 2'd1 ? AW'(4 * STEP - 1) : bte_q == 2'd2 ? AW'(8 * STEP - 1) :
                   bte_q == 2'd3 ? AW'(16 * STEP - 1) : '1;
   assign nxt = cti_q == 3'b010 ? (base & ~wrap_m) | ((base + AW'(STEP)) & wrap_m) : base;
   assign pres = state == IDLE ? wb.adr : state == WAIT ? beat : nxt;
   assign in_r = ({1'b0, pres} >= {1'b0, BASE_ADDR}) && ({1'b0, pres} < TOP);
   assign wr_en = ack_o & wb.we;
   assign wr_idx = beat[LB +: IW];
   assign rd_idx = pres[LB +: IW];
   always_comb begin
      wr_word = mem[wr_idx];
      for (int i = 0; i < STEP; i++)
         if (wb.sel[i]) wr_word[8*i +: 8] = wb.dat_w[8*i +: 8];
   end
   // write-first: a prefetch of the word being written this cycle sees the new data
   assign rd = (wr_en && wr_idx == rd_idx) ? wr_word : mem[rd_idx];
   always_comb begin
      state_n = state;
      cnt_n = cnt;
      present = 1'b0;
      lat = 1'b0;
      case (state)
         IDLE: if (req && !ack_o && !err_o) begin
            lat = 1'b1;
            state_n = WAIT_STATES > 0 ? WAIT : ACK;
            cnt_n = 4'(WAIT_STATES);
            present = WAIT_STATES == 0;
         end
         WAIT: begin
            cnt_n = req ? cnt - 4'd1 : 4'd0;
            state_n = !req ? IDLE : cnt == 4'd1 ? ACK : WAIT;
            present = req && cnt == 4'd1;
         end
         default: begin
            state_n = (req && ((state == ACK ? cti_q : wb.cti) inside {3'b001, 3'b010})) ? BURST : IDLE;
            present = state_n == BURST;
         end
      endcase
   end
   always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
      if (!wb_rst_i) begin
         state <= IDLE;
         cnt <= '0;
         beat <= '0;
         cti_q <= '0;
         bte_q <= '0;
         ack_q <= 1'b0;
         err_q <= 1'b0;
         dat_q <= '0;
      end else begin
         state <= state_n;
         cnt <= cnt_n;
         ack_q <= present & in_r;
         err_q <= present & !in_r;
         dat_q <= (present & in_r) ? rd : '0;
         if (lat | present) beat <= pres;
         if (lat) begin
            cti_q <= wb.cti;
            bte_q <= wb.bte;
         end
      end
   end
   always_ff @(posedge wb_clk_i)
      if (wr_en) mem[wr_idx] <= wr_word;
endmodule

// File: tb/tb_peripheral_wb_burst_ram.sv
// tb_peripheral_wb_burst_ram: table-driven Wishbone transfers with a response scoreboard, plus wait/reset corner cases.
module tb_peripheral_wb_burst_ram;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;
   peripheral_wb_burst_ram_if #(.AW(32), .DW(32)) b0 ();
   peripheral_wb_burst_ram_if #(.AW(32), .DW(32)) b3 ();
   peripheral_wb_burst_ram #(.WAIT_STATES(0)) dut0 (.wb_clk_i(clk), .wb_rst_i(rst_n), .wb(b0));
   peripheral_wb_burst_ram #(.WAIT_STATES(3)) dut3 (.wb_clk_i(clk), .wb_rst_i(rst_n), .wb(b3));
   typedef struct {
      logic        err;
      logic        chk;
      logic [31:0] dat;
   } exp_t;
   typedef struct {
      logic [31:0] adr;
      logic [31:0] dat;
      logic [3:0]  sel;
      logic        we;
      logic [2:0]  cti;
      logic [1:0]  bte;
      logic        last;
      logic        err;
      logic [31:0] exp;
   } vec_t;
   localparam int NV = 33;
`ifdef PERIPHERAL_WB_ADDR_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif
   exp_t q[$];
   vec_t v[NV];
   int checks = 0;
   int errors = 0;
   task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %h want %h", n, got, want);
      end
   endtask
   function automatic vec_t mk(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                               input logic we, input logic [2:0] cti, input logic [1:0] bte,
                               input logic last, input logic err, input logic [31:0] exp);
      vec_t t;
      t.adr = adr; t.dat = dat; t.sel = sel; t.we = we; t.cti = cti;
      t.bte = bte; t.last = last; t.err = err; t.exp = exp;
      return t;
   endfunction
   always @(negedge clk) begin
      if (b0.ack | b0.err) begin
         exp_t e;
         if (q.size() == 0) chk("unexpected_resp", 32'(b0.ack), 32'(0));
         else begin
            e = q.pop_front();
            chk("resp_flags", 32'({b0.stb, b0.ack, b0.err}), 32'({1'b1, !e.err, e.err}));
            if (e.chk) chk("resp_data", b0.dat_r, e.dat);
         end
      end
   end
   task automatic push(input logic err, input logic c, input logic [31:0] d);
      exp_t e;
      e.err = err; e.chk = c; e.dat = d;
      q.push_back(e);
   endtask
   task automatic xfer(input vec_t t, input bit first);
      int w;
      b0.adr = t.adr; b0.dat_w = t.dat; b0.sel = t.sel; b0.we = t.we;
      b0.cti = t.cti; b0.bte = t.bte; b0.cyc = 1'b1; b0.stb = 1'b1;
      push(t.err, !t.we || t.err, t.exp);
      w = 0;
      do begin
         @(negedge clk);
         w++;
      end while (!(b0.ack | b0.err) && w < 20);
      chk("beat_latency", 32'(w), first ? 32'd2 : 32'd1);
      @(posedge clk);
      #1;
      if (t.last) begin
         b0.cyc = 1'b0; b0.stb = 1'b0; b0.we = 1'b0;
      end
   endtask
   initial begin
      int w, acks;
      bit first;
      b0.adr = '0; b0.dat_w = '0; b0.sel = '0; b0.we = 1'b0; b0.cyc = 1'b0; b0.stb = 1'b0; b0.cti = '0; b0.bte = '0;
      b3.adr = '0; b3.dat_w = '0; b3.sel = '0; b3.we = 1'b0; b3.cyc = 1'b0; b3.stb = 1'b0; b3.cti = '0; b3.bte = '0;
      v[0] = mk(32'h10, 32'hDEADBEEF, 4'hF, 1, 3'd0, 0, 1, 0, 0);
      v[1] = mk(32'h10, 0, 4'hF, 0, 3'd0, 0, 1, 0, 32'hDEADBEEF);
      v[2] = mk(32'h10, 32'h00AA0000, 4'h4, 1, 3'd0, 0, 1, 0, 0);
      v[3] = mk(32'h10, 0, 4'hF, 0, 3'd0, 0, 1, 0, 32'hDEAABEEF);
      for (int i = 0; i < 4; i++) begin
         v[4+i] = mk(32'h20 + 4*i, i + 1, 4'hF, 1, i == 3 ? 3'd7 : 3'd2, 0, i == 3, 0, 0);
         v[8+i] = mk(32'h20 + 4*i, 0, 4'hF, 0, 3'd0, 0, 1, 0, i + 1);
         v[12+i] = mk(32'h20 | ((8 + 4*i) & 32'hC), 0, 4'hF, 0, i == 3 ? 3'd7 : 3'd2, 2'd1, i == 3, 0, ((2 + i) % 4) + 1);
         v[22+i] = mk(32'h3F8 + 4*i, 0, 4'hF, 0, i == 3 ? 3'd7 : 3'd2, 0, i == 3, i >= 2,
                      i == 0 ? 32'h77 : i == 1 ? 32'h88 : 32'h0);
      end
      v[16] = mk(32'h400, 0, 4'hF, 0, 3'd0, 0, 1, 1, 0);
      v[17] = mk(32'h30, 32'h11, 4'hF, 1, 3'd0, 0, 1, 0, 0);
      v[18] = mk(32'h30, 32'h55, 4'hF, 1, 3'd1, 0, 0, 0, 0);
      v[19] = mk(32'h30, 0, 4'hF, 0, 3'd7, 0, 1, 0, 32'h55);
      v[20] = mk(32'h3F8, 32'h77, 4'hF, 1, 3'd2, 0, 0, 0, 0);
      v[21] = mk(32'h3FC, 32'h88, 4'hF, 1, 3'd7, 0, 1, 0, 0);
      v[26] = mk(32'h0, 32'hA5A50000, 4'hF, 1, 3'd2, 0, 0, 0, 0);
      v[27] = mk(32'h4, 32'h00005A5A, 4'hF, 1, 3'd7, 0, 1, 0, 0);
      v[28] = mk(32'h20, 0, 4'hF, 0, 3'd2, 0, 0, 0, 1);
      v[29] = mk(32'h24, 0, 4'hF, 0, 3'd2, 0, 0, 0, 2);
      v[30] = mk(32'h2C, 0, 4'hF, 0, 3'd2, 0, 0, CHK, CHK ? 32'h0 : 32'h3);
      v[31] = mk(32'h30, 0, 4'hF, 0, 3'd7, 0, 1, 0, CHK ? 32'h55 : 32'h4);
      v[32] = mk(32'h400, 32'hFFFFFFFF, 4'hF, 1, 3'd0, 0, 1, 1, 0);
      #23;
      chk("reset_ack", 32'(b0.ack), 0);
      chk("reset_err", 32'(b0.err), 0);
      chk("reset_dat", b0.dat_r, 0);
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;
      first = 1'b1;
      for (int i = 0; i < NV; i++) begin
         xfer(v[i], first);
         first = v[i].last;
      end
      // classic transfer held with stb high: ack, a forced gap, then a second ack
      b0.adr = 32'h10; b0.we = 1'b0; b0.cti = 3'd0; b0.cyc = 1'b1; b0.stb = 1'b1;
      push(0, 1, 32'hDEAABEEF);
      push(0, 1, 32'hDEAABEEF);
      repeat (2) @(negedge clk);
      chk("classic_ack1", 32'(b0.ack), 1);
      @(negedge clk);
      chk("classic_gap", 32'(b0.ack), 0);
      @(negedge clk);
      chk("classic_ack2", 32'(b0.ack), 1);
      @(posedge clk); #1 b0.cyc = 1'b0; b0.stb = 1'b0;
      b3.adr = 32'h0; b3.sel = 4'hF; b3.cyc = 1'b1; b3.stb = 1'b1;
      w = 0;
      do begin
         @(negedge clk);
         w++;
      end while (!(b3.ack | b3.err) && w < 20);
      chk("wait_latency", 32'(w), 5);
      chk("wait_no_err", 32'(b3.err), 0);
      @(posedge clk); #1 b3.cyc = 1'b0; b3.stb = 1'b0;
      @(negedge clk);
      chk("wait_ack_pulse", 32'(b3.ack), 0);
      @(posedge clk); #1 b3.cyc = 1'b1; b3.stb = 1'b1;
      repeat (2) @(negedge clk);
      @(posedge clk); #1 b3.cyc = 1'b0; b3.stb = 1'b0;
      acks = 0;
      repeat (8) begin
         @(negedge clk);
         acks += int'(b3.ack | b3.err);
      end
      chk("wait_abort", 32'(acks), 0);
      @(posedge clk); #1;
      xfer(mk(32'h0, 0, 4'hF, 0, 3'd2, 0, 0, 0, 32'hA5A50000), 1'b1);
      b0.adr = 32'h4;
      push(0, 1, 32'h00005A5A);
      @(negedge clk);
      chk("rst_beat2_ack", 32'(b0.ack), 1);
      #1 rst_n = 1'b0;
      #1;
      chk("rst_ack_drop", 32'(b0.ack), 0);
      chk("rst_dat_drop", b0.dat_r, 0);
      b0.cyc = 1'b0; b0.stb = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      xfer(mk(32'h0, 0, 4'hF, 0, 3'd0, 0, 1, 0, 32'hA5A50000), 1'b1);
      repeat (2) @(negedge clk);
      chk("queue_empty", 32'(q.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
